// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the TinyCPU control slice: ALU opcodes, instruction
// op codes, instruction field positions and the sequencer state encoding.
package tiny_cpu_pkg;

   // ALU opcode encoding (instruction bits [14:12] when op[3] == 0)
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_SHR = 3'b111;

   // Non-ALU instruction op codes; 1011..1110 are NOPs
   localparam logic [3:0] OP_LDI  = 4'b1000;
   localparam logic [3:0] OP_JZ   = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1010;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Instruction field bit positions
   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int ALUOP_HI = 14;
   localparam int ALUOP_LO = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 10;
   localparam int RS_HI    = 9;
   localparam int RS_LO    = 8;
   localparam int IMM_HI   = 7;
   localparam int IMM_LO   = 0;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WB    = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   // An op with the top bit clear is an ALU instruction
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op[3] == 1'b0);
   endfunction

endpackage

// File: rtl/tiny_cpu_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low reset; R0 is exported for the program output.
module tiny_cpu_regfile
   import tiny_cpu_pkg::*;
#(
   parameter int NUM_REGS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] raddr_a,
   input  logic [1:0] raddr_b,
   output logic [7:0] rdata_a,
   output logic [7:0] rdata_b,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata,
   output logic [7:0] r0
);

   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];

   // Next register contents: only the addressed entry changes on a write
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end else begin
         regs_d = regs_q;
      end
   end

   // Register storage with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];
   assign r0      = regs_q[0];

endmodule

// File: rtl/tiny_cpu_ctrl.sv
// TinyCPU multi-cycle sequencer: FETCH -> EXEC -> WB per instruction, HALT is
// terminal. Owns PC, IR, Z flag and the register file; drives the external ALU.
// Optional single-step mode is enabled by defining TINYCPU_SINGLE_STEP_EN,
// which adds the step input.
module tiny_cpu_ctrl
   import tiny_cpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         NUM_REGS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef TINYCPU_SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_valid,
   input  logic [15:0] imem_rdata,
   output logic [7:0]  alu_operand_a,
   output logic [7:0]  alu_operand_b,
   output logic [2:0]  alu_opcode,
   input  logic [7:0]  alu_result,
   input  logic        alu_zero,
   output logic [7:0]  r0_out,
   output logic        halted
);

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, z_d;
   logic [7:0]  res_q, res_d;
   logic        res_zero_q, res_zero_d;
   logic        req_q, req_d;
   logic        halted_q, halted_d;
`ifdef TINYCPU_SINGLE_STEP_EN
   logic        armed_q, armed_d;
`endif

   logic        accept_s;
   logic [3:0]  op_s;
   logic [7:0]  imm_s;
   logic        rf_we_s;
   logic [7:0]  rf_wdata_s;

   // req is only ever high in FETCH, so req & valid is a fetch handshake
   assign accept_s = req_q & imem_valid;
   assign op_s     = ir_q[OP_HI:OP_LO];
   assign imm_s    = ir_q[IMM_HI:IMM_LO];

   tiny_cpu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (ir_q[RD_HI:RD_LO]),
      .raddr_b (ir_q[RS_HI:RS_LO]),
      .rdata_a (alu_operand_a),
      .rdata_b (alu_operand_b),
      .we      (rf_we_s),
      .waddr   (ir_q[RD_HI:RD_LO]),
      .wdata   (rf_wdata_s),
      .r0      (r0_out)
   );

   // Sequencer next-state, datapath updates and next values of registered outputs
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      z_d        = z_q;
      res_d      = res_q;
      res_zero_d = res_zero_q;
      rf_we_s    = 1'b0;
      rf_wdata_s = res_q;
      case (state_q)
         ST_FETCH: begin
            if (accept_s) begin
               ir_d    = imem_rdata;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            res_d      = alu_result;
            res_zero_d = alu_zero;
            state_d    = ST_WB;
         end
         ST_WB: begin
            state_d = ST_FETCH;
            pc_d    = pc_q + 8'd1;
            if (is_alu_op(op_s)) begin
               rf_we_s    = 1'b1;
               rf_wdata_s = res_q;
               z_d        = res_zero_q;
            end else begin
               case (op_s)
                  OP_LDI: begin
                     rf_we_s    = 1'b1;
                     rf_wdata_s = imm_s;
                  end
                  OP_JZ: begin
                     if (z_q) begin
                        pc_d = imm_s;
                     end else begin
                        pc_d = pc_q + 8'd1;
                     end
                  end
                  OP_JMP: begin
                     pc_d = imm_s;
                  end
                  OP_HALT: begin
                     pc_d    = pc_q;
                     state_d = ST_HALT;
                  end
                  default: begin
                     pc_d = pc_q + 8'd1;
                  end
               endcase
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

`ifdef TINYCPU_SINGLE_STEP_EN
      // A step is only captured while idling in FETCH; it is consumed by the fetch
      if ((state_q == ST_FETCH) && !armed_q && step) begin
         armed_d = 1'b1;
      end else if (accept_s) begin
         armed_d = 1'b0;
      end else begin
         armed_d = armed_q;
      end
      req_d = (state_d == ST_FETCH) && armed_d;
`else
      req_d = (state_d == ST_FETCH);
`endif
      halted_d = (state_d == ST_HALT);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= 16'h0000;
         z_q        <= 1'b0;
         res_q      <= 8'h00;
         res_zero_q <= 1'b0;
         req_q      <= 1'b0;
         halted_q   <= 1'b0;
`ifdef TINYCPU_SINGLE_STEP_EN
         armed_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         z_q        <= z_d;
         res_q      <= res_d;
         res_zero_q <= res_zero_d;
         req_q      <= req_d;
         halted_q   <= halted_d;
`ifdef TINYCPU_SINGLE_STEP_EN
         armed_q    <= armed_d;
`endif
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign alu_opcode = ir_q[ALUOP_HI:ALUOP_LO];
   assign halted     = halted_q;

endmodule

// File: tb/tb_tiny_cpu_ctrl.sv
// Self-checking bench for tiny_cpu_ctrl: behavioural ALU, instruction memory
// and an instruction-level reference model of the TinyCPU ISA.
module tb_tiny_cpu_ctrl;
   import tiny_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_valid = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [7:0]  alu_operand_a, alu_operand_b, alu_result, r0_out;
   logic [2:0]  alu_opcode;
   logic        alu_zero, halted;
`ifdef TINYCPU_SINGLE_STEP_EN
   logic        step = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [7:0]  m_r [4];
   logic [7:0]  m_pc;
   logic        m_z;
   logic [15:0] m_ir;
   logic        m_halted;
   logic [15:0] mem [256];

   always #5 clk = ~clk;

   tiny_cpu_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef TINYCPU_SINGLE_STEP_EN
      .step          (step),
`endif
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_rdata    (imem_rdata),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_opcode    (alu_opcode),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .r0_out        (r0_out),
      .halted        (halted)
   );

   function automatic logic [7:0] alu_f(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
      case (opc)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_NOT: return ~a;
         ALU_SHL: return a << 1;
         ALU_SHR: return a >> 1;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_f(alu_opcode, alu_operand_a, alu_operand_b);
   assign alu_zero   = (alu_result == 8'h00);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_pc = 8'h00; m_z = 1'b0; m_ir = 16'h0000; m_halted = 1'b0;
   endtask

   // ISA semantics of one instruction
   task automatic model_exec(input logic [15:0] ins);
      logic [3:0] op;
      logic [1:0] rd, rs;
      logic [7:0] imm, res;
      op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
      m_ir = ins;
      if (op < 4'd8) begin
         res = alu_f(op[2:0], m_r[rd], m_r[rs]);
         m_r[rd] = res;
         m_z = (res == 8'h00);
         m_pc = m_pc + 8'd1;
      end else if (op == 4'd8) begin
         m_r[rd] = imm;
         m_pc = m_pc + 8'd1;
      end else if (op == 4'd9) begin
         m_pc = m_z ? imm : m_pc + 8'd1;
      end else if (op == 4'd10) begin
         m_pc = imm;
      end else if (op == 4'd15) begin
         m_halted = 1'b1;
      end else begin
         m_pc = m_pc + 8'd1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},    imem_req, 0);
      check_eq({tag, "_addr"},   imem_addr, 8'h00);
      check_eq({tag, "_halted"}, halted, 0);
      check_eq({tag, "_opcode"}, alu_opcode, 3'd0);
      check_eq({tag, "_opa"},    alu_operand_a, 8'h00);
      check_eq({tag, "_opb"},    alu_operand_b, 8'h00);
      check_eq({tag, "_r0"},     r0_out, 8'h00);
   endtask

   // Reset, then release with a stray valid that must be ignored while req=0
   task automatic apply_reset();
      rst_n = 1'b0; imem_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      model_reset();
      rst_n = 1'b1; imem_valid = 1'b1; imem_rdata = 16'hF000;
      @(negedge clk);
      imem_valid = 1'b0;
      check_eq("stray_valid_opcode", alu_opcode, 3'd0);
      check_eq("stray_valid_halted", halted, 0);
`ifdef TINYCPU_SINGLE_STEP_EN
      check_eq("no_step_req", imem_req, 0);
`else
      check_eq("req_rises", imem_req, 1);
`endif
   endtask

   task automatic abort_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Run one instruction at negedge granularity; abort_at 1 = reset in EXEC, 2 = in WB
   task automatic do_instr(input int waits, input int abort_at);
      logic [15:0] ins;
      int budget;
`ifdef TINYCPU_SINGLE_STEP_EN
      check_eq("step_idle", imem_req, 0);
      @(negedge clk);
      check_eq("step_idle2", imem_req, 0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
`else
      budget = 0;
      while (imem_req !== 1'b1 && budget < 8) begin
         @(negedge clk);
         budget++;
      end
`endif
      check_eq("fetch_req", imem_req, 1);
      check_eq("fetch_addr", imem_addr, m_pc);
      for (int w = 0; w < waits; w++) begin
         @(negedge clk);
         check_eq("wait_req", imem_req, 1);
         check_eq("wait_addr", imem_addr, m_pc);
         check_eq("wait_ir_opcode", alu_opcode, m_ir[14:12]);
         check_eq("wait_opa", alu_operand_a, m_r[m_ir[11:10]]);
      end
      ins = mem[m_pc];
      imem_valid = 1'b1; imem_rdata = ins;
      @(negedge clk);
      imem_valid = 1'b0; imem_rdata = 16'($urandom);
      check_eq("exec_req", imem_req, 0);
      check_eq("exec_opcode", alu_opcode, ins[14:12]);
      check_eq("exec_opa", alu_operand_a, m_r[ins[11:10]]);
      check_eq("exec_opb", alu_operand_b, m_r[ins[9:8]]);
      if (abort_at == 1) begin
         abort_reset("rst_exec");
         return;
      end
`ifdef TINYCPU_SINGLE_STEP_EN
      step = 1'b1;
`endif
      @(negedge clk);
`ifdef TINYCPU_SINGLE_STEP_EN
      step = 1'b0;
`endif
      if (abort_at == 2) begin
         abort_reset("rst_wb");
         return;
      end
      model_exec(ins);
      @(negedge clk);
      check_eq("r0_out", r0_out, m_r[0]);
      check_eq("halted", halted, m_halted);
      if (!m_halted) check_eq("next_addr", imem_addr, m_pc);
`ifdef TINYCPU_SINGLE_STEP_EN
      check_eq("post_req", imem_req, 0);
`else
      check_eq("post_req", imem_req, m_halted ? 0 : 1);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hB000;
      mem[8'h00] = 16'h8405;  // LDI R1,5
      mem[8'h01] = 16'h8803;  // LDI R2,3
      mem[8'h02] = 16'h0600;  // ADD R1,R2 -> 8
      mem[8'h03] = 16'h8007;  // LDI R0,7
      mem[8'h04] = 16'h1000;  // SUB R0,R0 -> 0, Z=1
      mem[8'h05] = 16'h9010;  // JZ 0x10 (taken)
      mem[8'h10] = 16'h8C01;  // LDI R3,1
      mem[8'h11] = 16'h0F00;  // ADD R3,R3 -> 2, Z=0
      mem[8'h12] = 16'h9020;  // JZ 0x20 (not taken)
      mem[8'h13] = 16'hA0FF;  // JMP 0xFF

      apply_reset();
      for (int i = 0; i < 5; i++) do_instr(0, 0);
      do_instr(4, 0);                        // delayed fetch of JZ
      check_eq("jz_taken_addr", imem_addr, 8'h10);
      check_eq("r0_zero", r0_out, 8'h00);
      for (int i = 0; i < 4; i++) do_instr(0, 0);
      check_eq("at_ff", imem_addr, 8'hFF);

      do_instr(0, 0);                        // NOP at 0xFF wraps
      check_eq("pc_wrap", imem_addr, 8'h00);
      mem[8'h00] = 16'hA0FF;
      do_instr(0, 0);
      mem[8'hFF] = 16'hA0FF;                 // tight loop
      for (int i = 0; i < 3; i++) begin
         do_instr(0, 0);
         check_eq("tight_loop", imem_addr, 8'hFF);
      end
      mem[8'hFF] = 16'hA040;
      do_instr(0, 0);

      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'hB;
      end
      for (int i = 0; i < 200; i++) do_instr(int'($urandom_range(0, 2)), 0);

      mem[m_pc] = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
      do_instr(0, 0);
      imem_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("halt_req", imem_req, 0);
         check_eq("halt_flag", halted, 1);
         check_eq("halt_pc", imem_addr, m_pc);
         check_eq("halt_r0", r0_out, m_r[0]);
         check_eq("halt_opa", alu_operand_a, m_r[m_ir[11:10]]);
      end
      imem_valid = 1'b0;

      mem[8'h00] = 16'h8009;                 // LDI R0,9
      mem[8'h01] = 16'h0100;                 // ADD R0,R1
      apply_reset();
      do_instr(0, 0);
      check_eq("ldi_r0", r0_out, 8'h09);
      do_instr(0, 1);
      mem[8'h00] = 16'h8055;
      do_instr(0, 2);
      @(negedge clk);
      check_eq("wb_lost", r0_out, 8'h00);
      do_instr(0, 0);
      check_eq("after_rst_r0", r0_out, 8'h55);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
